// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode and state encodings for the LED sequencer
package led_seq_pkg;
    typedef enum logic [1:0] {MODE_MWALK, MODE_MBAR, MODE_AWALK, MODE_ABOUNCE} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_AUTO_RUN, S_AUTO_PAUSE} state_t;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchroniser and stable-level debounce with rise pulse
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic sync1_q, sync2_q, level_q, level_d, rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic done;
    always_comb begin
        done    = sync2_q != level_q && cnt_q == CW'(DEBOUNCE_CYC - 1);
        cnt_d   = (sync2_q == level_q || done) ? '0 : cnt_q + CW'(1);
        level_d = done ? sync2_q : level_q;
        rise_d  = level_d & ~level_q;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end
    assign o_level = level_q;
    assign o_rise  = rise_q;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: push-button driven N-LED walk/bar sequencer with auto modes
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS       = 4,
    parameter int DEBOUNCE_CYC = 250_000,
    parameter int AUTO_DIV     = 25_000_000
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_SW1,
    input  logic [1:0]                       i_mode,
    output logic [N_LEDS-1:0]                o_led,
    output logic [$clog2(N_LEDS+1)-1:0]      o_pos,
    output logic                             o_step
);
    localparam int PW = $clog2(N_LEDS + 1);
    localparam int DW = $clog2(AUTO_DIV);
    state_t            state_q, state_d;
    mode_t             mode_q;
    logic [1:0]        mode_s1_q, mode_s2_q;
    logic [PW-1:0]     pos_q, pos_d;
    logic              dir_q, dir_d;
    logic [DW-1:0]     pre_q, pre_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              step_q, step_d;
    logic              db_level, db_rise, press, chg, tc, up, at_top, bar;
    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_SW1),
        .o_level (db_level),
        .o_rise  (db_rise)
    );
    always_comb begin
        press   = db_rise & db_level;
        chg     = mode_s2_q != mode_q;
        tc      = pre_q == DW'(AUTO_DIV - 1);
        at_top  = pos_q == PW'(N_LEDS);
        up      = dir_q ? !at_top : pos_q == PW'(1);
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        pre_d   = pre_q;
        if (chg) begin
            state_d = S_IDLE;
            pos_d   = '0;
            dir_d   = 1'b1;
            pre_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (press) begin
                    state_d = mode_q[1] ? S_AUTO_RUN : S_MANUAL;
                    pos_d   = PW'(1);
                    dir_d   = 1'b1;
                    pre_d   = '0;
                end
                S_MANUAL: if (press) begin
                    state_d = at_top ? S_IDLE : S_MANUAL;
                    pos_d   = at_top ? '0 : pos_q + PW'(1);
                end
                S_AUTO_RUN: if (press) begin
                    state_d = S_AUTO_PAUSE;
                    pre_d   = tc ? '0 : pre_q;
                end else if (tc) begin
                    pre_d = '0;
                    if (mode_q == MODE_ABOUNCE) begin
                        pos_d = up ? pos_q + PW'(1) : pos_q - PW'(1);
                        dir_d = up;
                    end else begin
                        pos_d = at_top ? PW'(1) : pos_q + PW'(1);
                    end
                end else begin
                    pre_d = pre_q + DW'(1);
                end
                S_AUTO_PAUSE: if (press) state_d = S_AUTO_RUN;
                default: ;
            endcase
        end
        step_d = pos_d != pos_q;
        bar    = mode_q == MODE_MBAR;
        for (int i = 0; i < N_LEDS; i++)
            led_d[i] = bar ? PW'(i) < pos_d : PW'(i + 1) == pos_d;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_MWALK;
            mode_s1_q <= 2'b00;
            mode_s2_q <= 2'b00;
            pos_q     <= '0;
            dir_q     <= 1'b1;
            pre_q     <= '0;
            led_q     <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_t'(mode_s2_q);
            mode_s1_q <= i_mode;
            mode_s2_q <= mode_s1_q;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            pre_q     <= pre_d;
            led_q     <= led_d;
            step_q    <= step_d;
        end
    end
    assign o_led  = led_q;
    assign o_pos  = pos_q;
    assign o_step = step_q;
endmodule
